// File: rtl/seq_mul_cla_if.sv
// Request/result bundle for the sequential shift-and-add multiplier.
interface seq_mul_cla_if #(
  parameter int unsigned WIDTH = 64
);
  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, a, b,
    output busy, done, product
  );
endinterface

// File: rtl/seq_mul_cla.sv
// Radix-2 shift-and-add unsigned multiplier; one partial-product add per cycle
// through a 64-bit carry-lookahead adder.

module cla_adder #(
  parameter int unsigned WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);
  localparam int unsigned NGRP = WIDTH / 4;

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] c;
  logic [NGRP-1:0]  grp_g;
  logic [NGRP-1:0]  grp_p;
  logic [NGRP:0]    gc;

  assign g = a & b;
  assign p = a ^ b;

  // 4-bit lookahead groups: group generate/propagate plus in-group carries
  for (genvar k = 0; k < NGRP; k++) begin : g_grp
    localparam int unsigned B = 4 * k;
    logic [3:0] gg;
    logic [3:0] pp;
    assign gg = g[B+3:B];
    assign pp = p[B+3:B];
    assign grp_g[k] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                    | (pp[3] & pp[2] & pp[1] & gg[0]);
    assign grp_p[k] = &pp;
    assign c[B]   = gc[k];
    assign c[B+1] = gg[0] | (pp[0] & gc[k]);
    assign c[B+2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & gc[k]);
    assign c[B+3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                  | (pp[2] & pp[1] & pp[0] & gc[k]);
  end

  // Group carries ripple between lookahead groups
  always_comb begin
    gc    = '0;
    gc[0] = c_in;
    for (int unsigned k = 0; k < NGRP; k++) begin
      gc[k+1] = grp_g[k] | (grp_p[k] & gc[k]);
    end
  end

  assign sum   = p ^ c;
  assign c_out = gc[NGRP];
endmodule

module seq_mul_cla #(
  parameter int unsigned WIDTH = 64
) (
  input  logic          clk,
  input  logic          rst,
  seq_mul_cla_if.slave  bus
);
  localparam int unsigned CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t               state, state_n;
  logic [WIDTH-1:0]     mcand, mcand_n;
  logic [WIDTH-1:0]     acc_hi, acc_hi_n;
  logic [WIDTH-1:0]     acc_lo, acc_lo_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [2*WIDTH-1:0]   product_q, product_n;
  logic                 busy_q, busy_n;
  logic                 done_q, done_n;

  logic [WIDTH-1:0]     add_b;
  logic [WIDTH-1:0]     sum;
  logic                 c_out;
  logic [2*WIDTH-1:0]   shifted;

  assign add_b = acc_lo[0] ? mcand : '0;

  cla_adder #(.WIDTH(WIDTH)) u_cla (
    .a     (acc_hi),
    .b     (add_b),
    .c_in  (1'b0),
    .sum   (sum),
    .c_out (c_out)
  );

  // 129-bit {c_out, sum, acc_lo} shifted right by one; the dropped bit is acc_lo[0]
  assign shifted = {c_out, sum, acc_lo[WIDTH-1:1]};

  // Next-state and next-output logic
  always_comb begin
    state_n   = state;
    mcand_n   = mcand;
    acc_hi_n  = acc_hi;
    acc_lo_n  = acc_lo;
    cnt_n     = cnt;
    product_n = product_q;
    busy_n    = 1'b0;
    done_n    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.start) begin
          mcand_n  = bus.a;
          acc_lo_n = bus.b;
          acc_hi_n = '0;
          cnt_n    = '0;
          busy_n   = 1'b1;
          state_n  = S_RUN;
        end
      end
      S_RUN: begin
        {acc_hi_n, acc_lo_n} = shifted;
        cnt_n  = cnt + CNT_W'(1);
        busy_n = 1'b1;
        if (cnt == CNT_W'(WIDTH - 1)) begin
          product_n = shifted;
          done_n    = 1'b1;
          state_n   = S_DONE;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      mcand     <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      cnt       <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_n;
      mcand     <= mcand_n;
      acc_hi    <= acc_hi_n;
      acc_lo    <= acc_lo_n;
      cnt       <= cnt_n;
      product_q <= product_n;
      busy_q    <= busy_n;
      done_q    <= done_n;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;
endmodule

// File: tb/tb_seq_mul_cla.sv
// Scoreboard bench for seq_mul_cla: driver queues expected products and timing,
// a negedge monitor checks busy, done timing, product value and product hold.
module tb_seq_mul_cla;
  localparam int unsigned W = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;

  seq_mul_cla_if #(.WIDTH(W)) bus ();

  seq_mul_cla #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] p;
    int unsigned  e;
    int unsigned  d;
  } exp_t;

  exp_t         sb[$];
  int unsigned  cyc = 0;
  logic         rst_q = 1'b1;
  logic [127:0] held = '0;
  int           n_vec = 0;
  int           n_bad = 0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: model of what the outputs must show in the cycle after each edge
  always @(negedge clk) begin
    exp_t x;
    logic exp_busy;
    if (rst_q) begin
      sb.delete();
      held = '0;
    end
    if (sb.size() > 0 && cyc > sb[0].d) begin
      check("timeout", 128'(cyc), 128'(sb[0].d));
      void'(sb.pop_front());
    end
    exp_busy = (sb.size() > 0) && (cyc >= sb[0].e);
    check("busy", 128'(bus.busy), 128'(exp_busy));
    if (bus.done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 128'(bus.done), 128'(1'b0));
      end else begin
        x = sb.pop_front();
        check("done_cycle", 128'(cyc), 128'(x.d));
        check("product", bus.product, x.p);
        held = x.p;
      end
    end
    check("hold", bus.product, held);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Expect an accept at edge 'e'; result shows 64 cycles later
  task automatic expect_op(input logic [63:0] a, input logic [63:0] b, input int unsigned e);
    exp_t x;
    x.p = 128'(a) * 128'(b);
    x.e = e;
    x.d = e + 64;
    sb.push_back(x);
  endtask

  task automatic issue(input logic [63:0] a, input logic [63:0] b);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    expect_op(a, b, cyc + 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && sb.size() > 0; i++) tick();
    tick();
    tick();
  endtask

  task automatic do_op(input logic [63:0] a, input logic [63:0] b);
    issue(a, b);
    tick();
    bus.start = 1'b0;
    wait_idle();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned e0;
    logic [63:0] ra, rb;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    rst       = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();

    do_op(64'd3, 64'd5);
    do_op('1, '1);
    do_op(64'd0, 64'h1234_5678_9ABC_DEF0);
    do_op(64'd1, 64'h8000_0000_0000_0001);

    // start pulse during RUN must be ignored
    issue(64'd7, 64'd6);
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    bus.start = 1'b1;
    bus.a     = 64'hFF;
    bus.b     = 64'hFF;
    tick();
    bus.start = 1'b0;
    wait_idle();

    // reset at RUN cycle 30, then a start right after reset release
    do_op(64'd3, 64'd5);
    issue('1, '1);
    tick();
    bus.start = 1'b0;
    repeat (29) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    issue(64'd2, 64'd9);
    tick();
    bus.start = 1'b0;
    wait_idle();

    // back-to-back with start held high
    issue(64'd2, 64'd3);
    e0 = cyc + 1;
    tick();
    bus.a = 64'd10;
    bus.b = 64'd10;
    expect_op(64'd10, 64'd10, e0 + 66);
    repeat (66) tick();
    bus.a = 64'hFFFF;
    bus.b = 64'h10001;
    expect_op(64'hFFFF, 64'h10001, e0 + 132);
    repeat (66) tick();
    bus.start = 1'b0;
    wait_idle();

    // randomized operands with a mix of magnitudes
    for (int n = 0; n < 20; n++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: ra = 64'($urandom_range(0, 1000));
        1: rb = '1;
        2: rb = 64'($urandom);
        default: ;
      endcase
      repeat ($urandom_range(0, 3)) tick();
      do_op(ra, rb);
    end

    repeat (5) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/seq_mul_cla.md
Name: seq_mul_cla

Overview:
- Sequential radix-2 shift-and-add unsigned multiplier.
- Sits directly upstream of the 64-bit `cla_adder` and drives it. One `cla_adder` instance (ports `a`, `b`, `c_in`, `sum`, `c_out`) forms the partial-product add each cycle.
- Result is registered and presented with a one-cycle done pulse; this is the first multi-cycle arithmetic block built on the CLA.

Parameters:
- WIDTH, 64, operand width. Must equal the `cla_adder` width (64); other values unsupported.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  64  multiplicand, captured on accepted start
- b  input  64  multiplier, captured on accepted start
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse, product valid
- product  output  128  unsigned a*b, registered

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE; busy=0, done=0, product=0.
  - Internal mcand, acc_hi, acc_lo, cnt all cleared.
  - rst has priority over every other input, in any state.
- States are IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge E is accepted: mcand<=a, acc_lo<=b, acc_hi<=0, cnt<=0, state<=RUN.
  - start=0: remain in IDLE.
- RUN, one iteration per edge:
  - Adder inputs: a=acc_hi, b=(acc_lo[0] ? mcand : 0), c_in=0.
  - Update: {acc_hi, acc_lo} <= {c_out, sum, acc_lo} >> 1, giving a 129-bit shift right by 1 with c_out entering the MSB.
  - cnt<=cnt+1.
  - On the iteration where cnt==WIDTH-1: product<={next acc_hi, next acc_lo}, state<=DONE.
- DONE: done=1 for exactly this one cycle, then state<=IDLE unconditionally.
- Latency: start accepted at edge E. RUN edges are E+1..E+64. done is high in the cycle following edge E+64 (64 cycles after acceptance) and cleared at edge E+65.
- busy: 1 from edge E through edge E+65; 0 otherwise.
- Earliest next accept is edge E+66 (start held high gives a back-to-back throughput of 1 result per 66 cycles).
- product:
  - Changes only at the RUN→DONE edge.
  - Holds its value through IDLE and through the next operation's RUN; never shows partial values.
- start while busy (RUN or DONE) is ignored. No queueing; `a`/`b` changes during busy have no effect.
- Arithmetic: unsigned only; full 128-bit result, no overflow. 0×x and x×0 yield 0 with the same fixed latency (no early termination).
- Reset mid-operation: at the next edge, abort to IDLE, product=0, no done pulse. A start asserted in the cycle after rst deasserts is accepted normally.

Test Plan:
- Basic: rst 2 cycles; a=3, b=5, start 1 cycle. Expected: busy=1 next cycle; done pulses exactly 64 cycles after acceptance; product=0xF; busy falls with done.
- Max operands: a=b=0xFFFFFFFFFFFFFFFF. Expected: product=0xFFFFFFFFFFFFFFFE0000000000000001, which exercises c_out every iteration.
- Zero and identity:
  - a=0, b=0x123456789ABCDEF0 → product=0.
  - a=1, b=0x8000000000000001 → product=0x00000000000000008000000000000001.
  - Both complete in 64 cycles.
- Ignored start: after a=7, b=6 is accepted, assert start with a=b=0xFF at cycle 10 of RUN. Expected: product=42 (0x2A); no second done; busy low afterwards.
- Reset mid-op:
  - After completing 3×5 (product=15), start a=b=0xFFFFFFFFFFFFFFFF, assert rst at RUN cycle 30. Expected: product=0, busy=0, no done.
  - Then a=2, b=9 → product=18.
- Back-to-back: start held high over 3 operand pairs {(2,3),(10,10),(0xFFFF,0x10001)}. Expected: done pulses exactly 66 cycles apart; products 6, 100, 0xFFFFFFFF; each held until the next done.
